scr1_timer_arb: RTL

SCR1_TIMER_ARB -- requirements
Module: scr1_timer_arb

---
 rtl/scr1_memif_pkg.sv | 44 ++++
 rtl/scr1_timer_arb.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/scr1_memif_pkg.sv
// ---------------------------------------------------------------------------
// scr1_memif_pkg
//   Shared data-memory interface types for the SCR1 memory-mapped blocks:
//   command, access width and response encodings, bus widths, and the state
//   type of the timer arbiter that sits in front of scr1_timer.
//
//   The zero encodings of command (RD) and width (BYTE) are what an idle bus
//   carries, so "drive the bus to zero" and "drive RD/BYTE" mean the same.
// ---------------------------------------------------------------------------
package scr1_memif_pkg;

  localparam int SCR1_DMEM_AWIDTH = 32;
  localparam int SCR1_DMEM_DWIDTH = 32;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10,
    SCR1_MEM_WIDTH_ERROR = 2'b11
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

  // Two-state arbiter FSM: either free to grant, or waiting on the timer.
  typedef enum logic {
    SCR1_TIMER_ARB_IDLE      = 1'b0,
    SCR1_TIMER_ARB_WAIT_RESP = 1'b1
  } type_scr1_timer_arb_fsm_e;

  // True once the target has produced a final (OK or error) response.
  function automatic logic scr1_mem_resp_done(input type_scr1_mem_resp_e resp);
    return (resp != SCR1_MEM_RESP_NOTRDY);
  endfunction

endpackage

// File: rtl/scr1_timer_arb.sv
// ---------------------------------------------------------------------------
// scr1_timer_arb
//   Two-requester arbiter in front of the single-ported scr1_timer slave.
//   Requester 0 is the core data-memory port, requester 1 the debug/system
//   bus. One transaction is outstanding at a time; a new one may be granted
//   in the same cycle the previous one completes, giving one transaction per
//   cycle when the timer answers immediately. A stuck timer is cut off after
//   TIMEOUT_CYC cycles with a forced error response.
//
// Parameters
//   TIMEOUT_CYC  cycles allowed in WAIT_RESP before a forced RDY_ER (2..255)
//
// Ports
//   clk, rst_n                       clock, synchronous active-low reset
//   m0_req/cmd/width/addr/wdata      requester 0 request
//   m0_req_ack, m0_rdata, m0_resp    requester 0 handshake and response
//   m1_*                             same as m0_*, requester 1
//   t_req/cmd/width/addr/wdata       request to the timer
//   t_req_ack, t_rdata, t_resp       timer handshake and response
// ---------------------------------------------------------------------------
module scr1_timer_arb
  import scr1_memif_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,

  input  logic                        m0_req,
  input  type_scr1_mem_cmd_e          m0_cmd,
  input  type_scr1_mem_width_e        m0_width,
  input  logic [SCR1_DMEM_AWIDTH-1:0] m0_addr,
  input  logic [SCR1_DMEM_DWIDTH-1:0] m0_wdata,
  output logic                        m0_req_ack,
  output logic [SCR1_DMEM_DWIDTH-1:0] m0_rdata,
  output type_scr1_mem_resp_e         m0_resp,

  input  logic                        m1_req,
  input  type_scr1_mem_cmd_e          m1_cmd,
  input  type_scr1_mem_width_e        m1_width,
  input  logic [SCR1_DMEM_AWIDTH-1:0] m1_addr,
  input  logic [SCR1_DMEM_DWIDTH-1:0] m1_wdata,
  output logic                        m1_req_ack,
  output logic [SCR1_DMEM_DWIDTH-1:0] m1_rdata,
  output type_scr1_mem_resp_e         m1_resp,

  output logic                        t_req,
  output type_scr1_mem_cmd_e          t_cmd,
  output type_scr1_mem_width_e        t_width,
  output logic [SCR1_DMEM_AWIDTH-1:0] t_addr,
  output logic [SCR1_DMEM_DWIDTH-1:0] t_wdata,
  input  logic                        t_req_ack,
  input  logic [SCR1_DMEM_DWIDTH-1:0] t_rdata,
  input  type_scr1_mem_resp_e         t_resp
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

  type_scr1_timer_arb_fsm_e state;
  logic                     rr;       // 0: m0 preferred on contention
  logic                     owner;    // requester of the outstanding transaction
  logic [7:0]               to_cnt;

  logic                     grant_en;
  logic                     grant0;
  logic                     grant1;
  logic                     winner;
  logic                     accept;
  logic                     timeout;
  type_scr1_mem_resp_e      own_resp;
  logic [SCR1_DMEM_DWIDTH-1:0] own_rdata;

  // Grant is open in IDLE, or in WAIT_RESP on the cycle the current
  // transaction completes. Holding reset closes it so that the bus looks
  // idle while rst_n is low, whatever state the flops still hold.
  always_comb begin
    grant_en = 1'b0;
    if (rst_n) begin
      grant_en = (state == SCR1_TIMER_ARB_IDLE) ||
                 ((state == SCR1_TIMER_ARB_WAIT_RESP) && scr1_mem_resp_done(t_resp));
    end
  end

  // Single requester wins outright; on contention the round-robin pointer
  // picks. A requester that drops req before ack simply loses the grant.
  always_comb begin
    grant0 = grant_en & m0_req & (~m1_req | ~rr);
    grant1 = grant_en & m1_req & (~m0_req |  rr);
    winner = grant1;
    accept = (grant0 | grant1) & t_req_ack;
  end

  // Request mux towards the timer; an ungranted bus is all zeros.
  always_comb begin
    t_req   = grant0 | grant1;
    t_cmd   = SCR1_MEM_CMD_RD;
    t_width = SCR1_MEM_WIDTH_BYTE;
    t_addr  = '0;
    t_wdata = '0;
    if (grant1) begin
      t_cmd   = m1_cmd;
      t_width = m1_width;
      t_addr  = m1_addr;
      t_wdata = m1_wdata;
    end else if (grant0) begin
      t_cmd   = m0_cmd;
      t_width = m0_width;
      t_addr  = m0_addr;
      t_wdata = m0_wdata;
    end
    m0_req_ack = t_req_ack & grant0;
    m1_req_ack = t_req_ack & grant1;
  end

  // Response path: only the owner of an outstanding transaction sees the
  // timer. On the last allowed NOTRDY cycle the arbiter substitutes an
  // error with zero data, so a hung timer cannot hang a requester.
  always_comb begin
    timeout   = (state == SCR1_TIMER_ARB_WAIT_RESP) &&
                (to_cnt == TIMEOUT_LAST) &&
                (t_resp == SCR1_MEM_RESP_NOTRDY);
    own_resp  = SCR1_MEM_RESP_NOTRDY;
    own_rdata = '0;
    if (rst_n && (state == SCR1_TIMER_ARB_WAIT_RESP)) begin
      if (timeout) begin
        own_resp  = SCR1_MEM_RESP_RDY_ER;
      end else begin
        own_resp  = t_resp;
        own_rdata = t_rdata;
      end
    end
    m0_resp  = SCR1_MEM_RESP_NOTRDY;
    m0_rdata = '0;
    m1_resp  = SCR1_MEM_RESP_NOTRDY;
    m1_rdata = '0;
    if (owner) begin
      m1_resp  = own_resp;
      m1_rdata = own_rdata;
    end else begin
      m0_resp  = own_resp;
      m0_rdata = own_rdata;
    end
  end

  // FSM. An accepted request always (re)loads owner, pointer and counter,
  // whether it comes from IDLE or back-to-back on a completion cycle; the
  // pointer then favours the requester that did not just win.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= SCR1_TIMER_ARB_IDLE;
      rr     <= 1'b0;
      owner  <= 1'b0;
      to_cnt <= '0;
    end else begin
      case (state)
        SCR1_TIMER_ARB_IDLE: begin
          if (accept) begin
            owner  <= winner;
            rr     <= ~winner;
            to_cnt <= '0;
            state  <= SCR1_TIMER_ARB_WAIT_RESP;
          end
        end
        SCR1_TIMER_ARB_WAIT_RESP: begin
          if (scr1_mem_resp_done(t_resp)) begin
            if (accept) begin
              owner  <= winner;
              rr     <= ~winner;
              to_cnt <= '0;
            end else begin
              state  <= SCR1_TIMER_ARB_IDLE;
            end
          end else if (timeout) begin
            state  <= SCR1_TIMER_ARB_IDLE;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end
        default: state <= SCR1_TIMER_ARB_IDLE;
      endcase
    end
  end

endmodule
